// File: rtl/alu_sweep_controller.sv
// ALU sweep controller: loads operands from byte switches, steps an op selector,
// and sweeps every ALU op capturing a rotate-XOR signature and OR'd flags.
module alu_sweep_controller #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 8,
    parameter int SETTLE  = 2,
    parameter logic [WIDTH-1:0] A_INIT = 16'hCAFE,
    parameter logic [WIDTH-1:0] B_INIT = 16'h1234,
    localparam int OPW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sw,
    input  logic             btn_load_a,
    input  logic             btn_load_b,
    input  logic             btn_next_op,
    input  logic             btn_run,
    input  logic [WIDTH-1:0] result,
    input  logic [4:0]       flags,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [OPW-1:0]   op_index,
    output logic [WIDTH-1:0] result_q,
    output logic [4:0]       flags_q,
    output logic [WIDTH-1:0] checksum,
    output logic [4:0]       flag_acc,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE    | manual operand load / op stepping, result tracked every clock
    // SETTLE  | waiting for the ALU to settle on the current op
    // CAPTURE | fold result into signature, advance or finish
    // DONE    | sweep finished, captured values held
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [OPW-1:0] OP_LAST     = OPW'(NUM_OPS - 1);
    localparam logic [CW-1:0]  SETTLE_LOAD = CW'(SETTLE - 1);

    logic [1:0]       state;
    logic [CW-1:0]    settle_cnt;
    logic [3:0]       btn_now;
    logic [3:0]       btn_prev;
    logic [3:0]       btn_edge;
    logic             edge_load_a;
    logic             edge_load_b;
    logic             edge_next_op;
    logic             edge_run;
    logic [WIDTH-1:0] a_shifted;
    logic [WIDTH-1:0] b_shifted;
    logic [WIDTH-1:0] checksum_next;
    logic [OPW-1:0]   op_next;

    assign btn_now      = {btn_run, btn_next_op, btn_load_b, btn_load_a};
    assign btn_edge     = btn_now & ~btn_prev;
    assign edge_load_a  = btn_edge[0];
    assign edge_load_b  = btn_edge[1];
    assign edge_next_op = btn_edge[2];
    assign edge_run     = btn_edge[3];

    // Previous samples reset high so a button held through reset must be re-pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= 4'hF;
        end else begin
            btn_prev <= btn_now;
        end
    end

    generate
        if (WIDTH == 8) begin : g_shift_narrow
            assign a_shifted = sw;
            assign b_shifted = sw;
        end else begin : g_shift_wide
            assign a_shifted = {a[WIDTH-9:0], sw};
            assign b_shifted = {b[WIDTH-9:0], sw};
        end
    endgenerate

    assign checksum_next = {checksum[WIDTH-2:0], checksum[WIDTH-1]} ^ result;
    assign op_next       = (op_index == OP_LAST) ? '0 : op_index + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            a          <= A_INIT;
            b          <= B_INIT;
            op_index   <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            checksum   <= '0;
            flag_acc   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_IDLE) begin
                        result_q <= result;
                        flags_q  <= flags;
                    end
                    if (edge_run) begin
                        op_index   <= '0;
                        checksum   <= '0;
                        flag_acc   <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end else begin
                        if (edge_load_a) a <= a_shifted;
                        if (edge_load_b) b <= b_shifted;
                        if (edge_next_op) op_index <= op_next;
                        if (edge_load_a || edge_load_b || edge_next_op) state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    result_q <= result;
                    flags_q  <= flags;
                    checksum <= checksum_next;
                    flag_acc <= flag_acc | flags;
                    if (op_index == OP_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        op_index   <= op_index + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_sweep_controller.sv
// Randomized bench for alu_sweep_controller against a transaction-level model.
module tb_alu_sweep_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic        btn_load_a, btn_load_b, btn_next_op, btn_run;
    logic [15:0] result;
    logic [4:0]  flags;
    logic [15:0] a, b, result_q, checksum;
    logic [2:0]  op_index;
    logic [4:0]  flags_q, flag_acc;
    logic        busy, done;
    logic        force_const;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_a, exp_b;
    int          exp_op;

    alu_sweep_controller dut (
        .clk(clk), .reset(reset), .sw(sw),
        .btn_load_a(btn_load_a), .btn_load_b(btn_load_b),
        .btn_next_op(btn_next_op), .btn_run(btn_run),
        .result(result), .flags(flags),
        .a(a), .b(b), .op_index(op_index),
        .result_q(result_q), .flags_q(flags_q),
        .checksum(checksum), .flag_acc(flag_acc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y, input int op);
        case (op)
            0: return x + y;
            1: return x - y;
            2: return x & y;
            3: return x | y;
            4: return x ^ y;
            5: return x << 1;
            6: return x >> 1;
            default: return ~x;
        endcase
    endfunction

    function automatic logic [4:0] flg_f(input logic [15:0] r);
        return {^r, r[15], r == 16'h0, r[1], r[0]};
    endfunction

    always_comb begin
        result = 16'h0;
        flags  = 5'h0;
        if (force_const) begin
            result = 16'h0001;
            flags  = 5'b00010;
        end else begin
            result = alu_f(a, b, int'(op_index));
            flags  = flg_f(alu_f(a, b, int'(op_index)));
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 load_a, 1 load_b, 2 next_op; edge fires on the first clock
    task automatic press(input int which, input logic [7:0] val);
        sw = val;
        case (which)
            0: btn_load_a  = 1'b1;
            1: btn_load_b  = 1'b1;
            default: btn_next_op = 1'b1;
        endcase
        tick();
        btn_load_a = 1'b0; btn_load_b = 1'b0; btn_next_op = 1'b0;
        tick();
        case (which)
            0: exp_a = {exp_a[7:0], val};
            1: exp_b = {exp_b[7:0], val};
            default: exp_op = (exp_op + 1) % 8;
        endcase
    endtask

    task automatic run_sweep(input logic inject);
        logic [15:0] exp_ck, r;
        logic [4:0]  exp_fa;
        int nb;
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        check_val("run_busy", busy, 1);
        check_val("run_ck_clr", checksum, 0);
        check_val("run_fa_clr", flag_acc, 0);
        nb = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (busy) begin
                nb++;
                check_val("sweep_op", op_index, k / 3);
            end
            if (inject && k == 5) begin
                sw = 8'($urandom);
                btn_load_a = 1'b1; btn_next_op = 1'b1; btn_run = 1'b1;
            end
            if (inject && k == 8) begin
                btn_load_a = 1'b0; btn_next_op = 1'b0; btn_run = 1'b0;
            end
            tick();
        end
        check_val("sweep_done", done, 1);
        check_val("sweep_len", nb, 24);
        check_val("sweep_op_hold", op_index, 7);
        check_val("sweep_a_kept", a, exp_a);
        if (force_const) begin
            exp_ck = 16'h00FF;
            exp_fa = 5'b00010;
            r = 16'h0001;
        end else begin
            exp_ck = 16'h0;
            exp_fa = 5'h0;
            r = 16'h0;
            for (int i = 0; i < 8; i++) begin
                r = alu_f(exp_a, exp_b, i);
                exp_ck = {exp_ck[14:0], exp_ck[15]} ^ r;
                exp_fa = exp_fa | flg_f(r);
            end
        end
        check_val("sweep_checksum", checksum, exp_ck);
        check_val("sweep_flag_acc", flag_acc, exp_fa);
        check_val("sweep_result_q", result_q, r);
        check_val("sweep_flags_q", flags_q, force_const ? 5'b00010 : flg_f(r));
        exp_op = 7;
        tick();
        tick();
        check_val("done_hold_ck", checksum, exp_ck);
        check_val("done_hold", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sw = 8'h0; force_const = 1'b0;
        btn_load_a = 1'b0; btn_load_b = 1'b0; btn_next_op = 1'b0; btn_run = 1'b0;
        exp_a = 16'hCAFE; exp_b = 16'h1234; exp_op = 0;
        tick(); tick();
        check_val("rst_a", a, 16'hCAFE);
        check_val("rst_b", b, 16'h1234);
        check_val("rst_op", op_index, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ck", checksum, 0);
        check_val("rst_result_q", result_q, 0);
        reset = 1'b0;
        tick();

        press(0, 8'h12);
        check_val("load_a_1", a, 16'hFE12);
        press(0, 8'h34);
        check_val("load_a_2", a, 16'h1234);
        check_val("load_a_b_kept", b, 16'h1234);

        sw = 8'h56;
        btn_load_b = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        btn_load_b = 1'b0;
        tick();
        exp_b = 16'h3456;
        check_val("load_b_held", b, exp_b);

        for (int i = 0; i < 8; i++) begin
            press(2, 8'h0);
            check_val("next_op", op_index, exp_op);
        end
        check_val("next_op_wrap", op_index, 0);
        check_val("idle_result_q", result_q, alu_f(exp_a, exp_b, exp_op));

        force_const = 1'b1;
        run_sweep(1'b1);
        force_const = 1'b0;
        run_sweep(1'b0);

        for (int it = 0; it < 6; it++) begin
            int nl = $urandom_range(1, 4);
            for (int j = 0; j < nl; j++) begin
                press($urandom_range(0, 2), 8'($urandom));
                check_val("rnd_done_clr", done, 0);
                check_val("rnd_a", a, exp_a);
                check_val("rnd_b", b, exp_b);
                check_val("rnd_op", op_index, exp_op);
                check_val("rnd_result_q", result_q, alu_f(exp_a, exp_b, exp_op));
                check_val("rnd_flags_q", flags_q, flg_f(alu_f(exp_a, exp_b, exp_op)));
            end
            run_sweep(it[0]);
        end

        press(1, 8'hA5);
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check_val("mid_op3", op_index, 3);
        check_val("mid_busy", busy, 1);
        reset = 1'b1;
        btn_run = 1'b1;
        tick();
        check_val("abort_busy", busy, 0);
        check_val("abort_op", op_index, 0);
        check_val("abort_ck", checksum, 0);
        check_val("abort_a", a, 16'hCAFE);
        exp_a = 16'hCAFE; exp_b = 16'h1234; exp_op = 0;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_val("held_run_no_start", busy, 0);
        btn_run = 1'b0;
        tick();
        run_sweep(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sweep_controller.md
ALU_SWEEP_CONTROLLER -- requirements
Module: alu_sweep_controller

Interface
REQ-001 Parameter WIDTH, default 16, ALU operand/result width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter NUM_OPS, default 8, number of ALU operations selectable (2..16).
REQ-003 Parameter SETTLE, default 2, clocks the ALU is allowed to settle per op during a sweep; SHALL be at least 1.
REQ-004 Parameters A_INIT / B_INIT, defaults 16'hCAFE / 16'h1234, reset values of operands a / b.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sw  input  8  byte shifted into an operand on a load press.
REQ-008 btn_load_a, btn_load_b, btn_next_op, btn_run  input  1 each  debounced button levels.
REQ-009 result  input  WIDTH  combinational ALU result for current a, b, op_index.
REQ-010 flags  input  5  combinational ALU flags.
REQ-011 a, b  output  WIDTH  registered operands driven to the ALU.
REQ-012 op_index  output  clog2(NUM_OPS)  registered operation selector; external logic maps it to an opcode.
REQ-013 result_q  output  WIDTH  captured result; flags_q  output  5  captured flags.
REQ-014 checksum  output  WIDTH  sweep signature; flag_acc  output  5  OR of all flags captured in a sweep.
REQ-015 busy  output  1  sweep in progress; done  output  1  sweep complete.

Function
REQ-016 Each button SHALL pass through an edge detector: an action fires on the clk edge where the button is sampled 1 and its previous sample was 0; holding a button SHALL fire exactly once.
REQ-017 FSM states SHALL be IDLE, SETTLE, CAPTURE, DONE; busy = SETTLE or CAPTURE; done = DONE.
REQ-018 IDLE: a load_a edge SHALL do a <= {a[WIDTH-9:0], sw}; load_b likewise on b; both may fire in the same cycle.
REQ-019 IDLE: a next_op edge SHALL increment op_index, wrapping NUM_OPS-1 -> 0.
REQ-020 IDLE: result_q/flags_q SHALL register result/flags every clock (1-cycle latency).
REQ-021 IDLE or DONE: a run edge SHALL take priority over all other same-cycle edges (those are discarded); it sets op_index 0, checksum 0, flag_acc 0, settle counter SETTLE-1, next state SETTLE.
REQ-022 SETTLE: counter decrements each clock; when it is 0, next state CAPTURE (SETTLE clocks total).
REQ-023 CAPTURE: result_q <= result; flags_q <= flags; checksum <= rotate-left-1(checksum) XOR result; flag_acc <= flag_acc | flags.
REQ-024 CAPTURE with op_index = NUM_OPS-1 -> DONE, op_index held; otherwise op_index + 1, counter reloaded to SETTLE-1, -> SETTLE.
REQ-025 A sweep SHALL take NUM_OPS*(SETTLE+1) clocks from the run-edge clock to the first clock done = 1.
REQ-026 While busy, all load, next_op and run edges SHALL be ignored; a, b unchanged.
REQ-027 DONE: result_q, flags_q, checksum and flag_acc held; a load or next_op edge SHALL perform its IDLE action and go to IDLE.

Reset
REQ-028 On reset: a = A_INIT, b = B_INIT, op_index 0, result_q 0, flags_q 0, checksum 0, flag_acc 0, state IDLE, busy 0, done 0.
REQ-029 Edge-detector previous-sample registers SHALL reset to 1, so a button held through reset does not fire until released and re-pressed.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with the same values on the following clock.

Verification (WIDTH=16, NUM_OPS=8, SETTLE=2)
REQ-031 Reset pulse -> a=CAFE, b=1234, op_index 0, busy 0, done 0, checksum 0.
REQ-032 sw=12 load_a press, then sw=34 load_a press -> a=FE12 then a=1234; b unchanged.
REQ-033 load_b held 10 clocks -> exactly one shift; 8 separate next_op presses -> op_index 1..7, then back to 0.
REQ-034 result tied 0001, flags 00010, run press -> busy 24 clocks, op_index 0..7, then done=1, checksum=00FF, flag_acc=00010.
REQ-035 load_a press and next_op press during sweep -> a, op_index unaffected; run press in DONE restarts the sweep with checksum cleared.
REQ-036 Reset during SETTLE at op_index 3 -> next clock IDLE, op_index 0, checksum 0, busy 0; run held through reset does not start a sweep.
